// File: rtl/smm_pkg.sv
// -----------------------------------------------------------------------------
// smm_pkg
// Definitions shared by the Strassen matrix-multiply core and its feed/drain
// companions. Keeping them here means both sides use the same result-bus layout.
//   - drain_state_e  : IDLE / WAIT / DRAIN encoding for the result drain
//   - blk_e          : the four 2x2 sub-blocks of the 4x4 result (C11..C22)
//   - blk_row0/col0  : top-left element of each sub-block
//   - elem_lsb       : bit offset of element (row,col) on the flat 4x4 bus
// -----------------------------------------------------------------------------
package smm_pkg;

    localparam int N_DIM  = 4;
    localparam int N_ELEM = N_DIM * N_DIM;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

    // Sub-block numbering matches the core: bit 1 selects the lower rows,
    // bit 0 selects the right-hand columns.
    typedef enum logic [1:0] {
        BLK_C11 = 2'd0,
        BLK_C12 = 2'd1,
        BLK_C21 = 2'd2,
        BLK_C22 = 2'd3
    } blk_e;

    function automatic logic [1:0] blk_row0(input blk_e b);
        return {b[1], 1'b0};
    endfunction

    function automatic logic [1:0] blk_col0(input blk_e b);
        return {b[0], 1'b0};
    endfunction

    // Row-major layout: element (r,c) occupies [(4r+c)*dw +: dw].
    function automatic int elem_lsb(input int row, input int col, input int dw);
        return (N_DIM * row + col) * dw;
    endfunction

endpackage

// File: rtl/smm_latency_timer.sv
// -----------------------------------------------------------------------------
// smm_latency_timer
// Loadable down-counter with a zero flag. Loading takes priority over counting;
// once the count reaches zero it parks there until the next load.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val into the counter
//   i_load_val     : value to load
//   i_en           : decrement by one this cycle (if non-zero)
//   o_zero         : counter currently holds zero
// -----------------------------------------------------------------------------
module smm_latency_timer #(
    parameter int CW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_en && (r_cnt != '0))
            r_cnt <= r_cnt - CW'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/smm_result_drain.sv
// -----------------------------------------------------------------------------
// smm_result_drain
// Reader-side companion of the Strassen core. A load strobe starts a LATENCY
// cycle wait, after which the whole 4x4 result bus is captured and streamed
// out one element per handshake, row-major. In half mode only columns 0-1
// are streamed.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : core load strobe (starts a capture)
//   i_sel          : core mode at load time, 1 = half mode
//   i_c_in         : core flat result bus
//   o_m_valid/i_m_ready : output handshake
//   o_m_data/o_m_row/o_m_col : element value and its position
//   o_m_last       : last element of this matrix
//   o_busy         : waiting or draining
//   o_overrun      : one-cycle pulse when a load had to be dropped
// -----------------------------------------------------------------------------
module smm_result_drain
    import smm_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int BLOCKSIZE = DATAWIDTH * 4,
    parameter int BUSWIDTH  = BLOCKSIZE * 4,
    parameter int LATENCY   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_load,
    input  logic                        i_sel,
    input  logic [BUSWIDTH-1:0]         i_c_in,
    output logic                        o_m_valid,
    input  logic                        i_m_ready,
    output logic signed [DATAWIDTH-1:0] o_m_data,
    output logic [1:0]                  o_m_row,
    output logic [1:0]                  o_m_col,
    output logic                        o_m_last,
    output logic                        o_busy,
    output logic                        o_overrun
);

    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

    drain_state_e        r_state, w_next;
    logic                r_mode;
    logic [3:0]          r_idx;
    logic [BUSWIDTH-1:0] r_buf;
    logic                r_overrun;

    logic       w_zero, w_hs, w_final, w_accept, w_capture, w_last;
    logic [1:0] w_row, w_col;

    // Element index to position. Half mode packs columns 0-1 densely.
    always_comb begin
        if (r_mode) begin
            w_row  = r_idx[2:1];
            w_col  = {1'b0, r_idx[0]};
            w_last = (r_idx == 4'd7);
        end else begin
            w_row  = r_idx[3:2];
            w_col  = r_idx[1:0];
            w_last = (r_idx == 4'd15);
        end
    end

    assign w_hs      = (r_state == ST_DRAIN) && i_m_ready;
    assign w_final   = w_hs && w_last;
    // A load coinciding with the final handshake is taken, not dropped.
    assign w_accept  = i_load && ((r_state == ST_IDLE) || w_final);
    assign w_capture = (r_state == ST_WAIT) && w_zero;

    smm_latency_timer #(.CW(CW)) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_accept),
        .i_load_val (LOAD_VAL),
        .i_en       (r_state == ST_WAIT),
        .o_zero     (w_zero)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_load)    w_next = ST_WAIT;
            ST_WAIT:  if (w_zero)    w_next = ST_DRAIN;
            ST_DRAIN: if (w_final)   w_next = i_load ? ST_WAIT : ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode    <= 1'b0;
            r_idx     <= '0;
            r_buf     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_accept;
            if (w_accept)
                r_mode <= i_sel;
            if (w_capture) begin
                r_buf <= i_c_in;
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // Outputs depend only on registered state, so m_ready never reaches m_valid.
    always_comb begin
        o_m_valid = (r_state == ST_DRAIN);
        o_m_data  = '0;
        o_m_row   = '0;
        o_m_col   = '0;
        o_m_last  = 1'b0;
        if (r_state == ST_DRAIN) begin
            o_m_data = r_buf[elem_lsb(int'(w_row), int'(w_col), DATAWIDTH) +: DATAWIDTH];
            o_m_row  = w_row;
            o_m_col  = w_col;
            o_m_last = w_last;
        end
        o_busy    = (r_state != ST_IDLE);
        o_overrun = r_overrun;
    end

endmodule
